// File: rtl/safe_pkg.sv
// Shared types and helpers for the combination-lock controller.
package safe_pkg;

    localparam int STATE_W   = 2;
    localparam int POP_MAX_W = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_OPEN    = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKOUT = 2'd3
    } safe_state_t;

    // Counts set bits among the low 'width' bits of v; callers zero-extend narrower codes.
    function automatic logic [7:0] popcount(input logic [POP_MAX_W-1:0] v, input int width);
        logic [7:0] sum;
        sum = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            if (i < width) begin
                sum = sum + 8'(v[i]);
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/safe_lockout_timer.sv
// Loadable down-counter that times the lockout; holds at zero once expired.
module safe_lockout_timer #(
    parameter int CW = 28
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          enable,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/safe_lock_core.sv
// Combination-lock controller: stores a password, checks attempts, limits retries
// and enforces a timed lockout with an alarm flag.
module safe_lock_core
    import safe_pkg::*;
#(
    parameter int W              = 10,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 250_000_000,
    parameter int HINT_EN        = 1,
    localparam int HW            = $clog2(W + 1),
    localparam int TW            = $clog2(MAX_TRIES + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enter,
    input  logic [W-1:0]       code_in,
    output logic               locked,
    output logic               alarm,
    output logic [STATE_W-1:0] state,
    output logic [HW-1:0]      hint,
    output logic [TW-1:0]      tries_left,
    output logic               unlock_pulse,
    output logic               fail_pulse
);

    localparam int CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    safe_state_t state_q;
    logic [W-1:0] password;
    logic [W-1:0] attempt;
    logic         enter_q;
    logic         press;
    logic         match;
    logic         last_try;
    logic         timer_load;
    logic         timer_en;
    logic         timer_zero;

    // enter_q resets high so a button held through reset release is not seen as a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            enter_q <= 1'b1;
        end else begin
            enter_q <= enter;
        end
    end

    assign press    = enter & ~enter_q;
    assign match    = (attempt == password);
    assign last_try = (tries_left == TW'(1));

    assign timer_load = (state_q == ST_CHECK) && !match && last_try;
    assign timer_en   = (state_q == ST_LOCKOUT);

    safe_lockout_timer #(
        .CW(CW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .enable  (timer_en),
        .load_val(CW'(LOCKOUT_CYCLES - 1)),
        .zero    (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_OPEN;
            password     <= '0;
            attempt      <= '0;
            tries_left   <= TW'(MAX_TRIES);
            unlock_pulse <= 1'b0;
            fail_pulse   <= 1'b0;
        end else begin
            unlock_pulse <= 1'b0;
            fail_pulse   <= 1'b0;
            case (state_q)
                ST_OPEN: begin
                    if (press) begin
                        password   <= code_in;
                        tries_left <= TW'(MAX_TRIES);
                        state_q    <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (press) begin
                        attempt <= code_in;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (match) begin
                        unlock_pulse <= 1'b1;
                        tries_left   <= TW'(MAX_TRIES);
                        state_q      <= ST_OPEN;
                    end else begin
                        fail_pulse <= 1'b1;
                        tries_left <= tries_left - TW'(1);
                        state_q    <= last_try ? ST_LOCKOUT : ST_LOCKED;
                    end
                end
                ST_LOCKOUT: begin
                    // Presses here are dropped; the timer alone ends the lockout.
                    if (timer_zero) begin
                        tries_left <= TW'(MAX_TRIES);
                        state_q    <= ST_LOCKED;
                    end
                end
                default: state_q <= ST_OPEN;
            endcase
        end
    end

    assign state  = state_q;
    assign locked = (state_q != ST_OPEN);
    assign alarm  = (state_q == ST_LOCKOUT);

    generate
        if (HINT_EN != 0) begin : g_hint
            assign hint = (state_q == ST_LOCKED)
                        ? HW'(popcount(POP_MAX_W'(code_in ^ password), W))
                        : '0;
        end else begin : g_no_hint
            assign hint = '0;
        end
    endgenerate

endmodule

// File: tb/tb_safe_lock_core.sv
// Directed bench for safe_lock_core with W=10, MAX_TRIES=3, LOCKOUT_CYCLES=8.
module tb_safe_lock_core;
    import safe_pkg::*;

    localparam int W  = 10;
    localparam int MT = 3;
    localparam int LC = 8;

    logic          clk;
    logic          reset;
    logic          enter;
    logic [W-1:0]  code_in;
    logic          locked;
    logic          alarm;
    logic [1:0]    state;
    logic [3:0]    dut_hint;
    logic [1:0]    tries_left;
    logic          unlock_pulse;
    logic          fail_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    safe_lock_core #(
        .W(W), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC), .HINT_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .enter(enter), .code_in(code_in),
        .locked(locked), .alarm(alarm), .state(state), .hint(dut_hint),
        .tries_left(tries_left), .unlock_pulse(unlock_pulse), .fail_pulse(fail_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [W-1:0] c);
        enter   = 1'b1;
        code_in = c;
        step();
        check("arm_state", 32'(state), 32'(ST_LOCKED));
        check("arm_locked", 32'(locked), 32'd1);
        check("arm_tries", 32'(tries_left), 32'd3);
        enter = 1'b0;
        step();
    endtask

    task automatic do_attempt(input logic [W-1:0] c, input logic ok,
                              input logic [1:0] exp_tries, input logic [1:0] exp_state);
        enter   = 1'b1;
        code_in = c;
        step();
        check("chk_state", 32'(state), 32'(ST_CHECK));
        check("chk_pulses", 32'({unlock_pulse, fail_pulse}), 32'd0);
        enter = 1'b0;
        step();
        check("res_state", 32'(state), 32'(exp_state));
        check("res_unlock", 32'(unlock_pulse), 32'(ok));
        check("res_fail", 32'(fail_pulse), 32'(!ok));
        check("res_tries", 32'(tries_left), 32'(exp_tries));
    endtask

    initial begin
        int alarm_cnt;

        reset   = 1'b1;
        enter   = 1'b0;
        code_in = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_state", 32'(state), 32'(ST_OPEN));
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_hint", 32'(dut_hint), 32'd0);
        check("rst_tries", 32'(tries_left), 32'd3);
        check("rst_pulses", 32'({unlock_pulse, fail_pulse}), 32'd0);
        step();

        // Arm with 2A5 and probe the hint while still LOCKED.
        enter   = 1'b1;
        code_in = 10'h2A5;
        step();
        check("arm1_state", 32'(state), 32'(ST_LOCKED));
        check("arm1_tries", 32'(tries_left), 32'd3);
        check("hint_eq", 32'(dut_hint), 32'd0);
        code_in = 10'h2A4;
        #1;
        check("hint_1", 32'(dut_hint), 32'd1);
        code_in = 10'h15A;
        #1;
        check("hint_10", 32'(dut_hint), 32'd10);
        enter = 1'b0;
        step();

        do_attempt(10'h2A5, 1'b1, 2'd3, ST_OPEN);
        check("open_locked", 32'(locked), 32'd0);
        code_in = 10'h15A;
        step();
        check("unlock_1cyc", 32'(unlock_pulse), 32'd0);
        check("hint_open", 32'(dut_hint), 32'd0);

        // One long press arms exactly once and never reaches CHECK.
        enter   = 1'b1;
        code_in = 10'h001;
        step();
        check("long_arm", 32'(state), 32'(ST_LOCKED));
        for (int i = 0; i < 9; i++) step();
        check("long_hold", 32'(state), 32'(ST_LOCKED));
        enter = 1'b0;
        step();

        // Two wrong attempts then a correct one restores the full retry count.
        do_attempt(10'h000, 1'b0, 2'd2, ST_LOCKED);
        do_attempt(10'h000, 1'b0, 2'd1, ST_LOCKED);
        do_attempt(10'h001, 1'b1, 2'd3, ST_OPEN);
        step();

        // Three fails into lockout, with presses hammered during the lockout.
        arm(10'h001);
        do_attempt(10'h000, 1'b0, 2'd2, ST_LOCKED);
        do_attempt(10'h000, 1'b0, 2'd1, ST_LOCKED);
        do_attempt(10'h000, 1'b0, 2'd0, ST_LOCKOUT);
        check("lo_alarm", 32'(alarm), 32'd1);
        alarm_cnt = 0;
        for (int k = 0; k < 20 && alarm; k++) begin
            alarm_cnt++;
            enter   = (k % 2 == 0);
            code_in = 10'h001;
            step();
        end
        check("lo_cycles", 32'(alarm_cnt), 32'(LC));
        check("lo_exit_state", 32'(state), 32'(ST_LOCKED));
        check("lo_exit_tries", 32'(tries_left), 32'd3);
        enter = 1'b0;
        step();
        check("lo_no_queue", 32'(state), 32'(ST_LOCKED));

        // Reset in the fourth lockout cycle.
        do_attempt(10'h000, 1'b0, 2'd2, ST_LOCKED);
        do_attempt(10'h000, 1'b0, 2'd1, ST_LOCKED);
        do_attempt(10'h000, 1'b0, 2'd0, ST_LOCKOUT);
        step();
        step();
        step();
        check("lo4_alarm", 32'(alarm), 32'd1);
        reset = 1'b1;
        step();
        check("mrst_state", 32'(state), 32'(ST_OPEN));
        check("mrst_alarm", 32'(alarm), 32'd0);
        check("mrst_tries", 32'(tries_left), 32'd3);
        check("mrst_locked", 32'(locked), 32'd0);

        // Enter held high across reset release must not arm.
        enter = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("held_state", 32'(state), 32'(ST_OPEN));
        end
        enter = 1'b0;
        step();

        // Password 0 is legal, and re-arming with the same password works.
        arm(10'h000);
        check("pw0_hint", 32'(dut_hint), 32'd0);
        do_attempt(10'h000, 1'b1, 2'd3, ST_OPEN);
        step();
        arm(10'h000);
        do_attempt(10'h3FF, 1'b0, 2'd2, ST_LOCKED);
        do_attempt(10'h000, 1'b1, 2'd3, ST_OPEN);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
